// File: rtl/ysyx_22040237_ifu.sv
// Multi-cycle instruction fetch unit: PC, valid/ready memory fetch, decode handoff, redirects, sticky fault.
module ysyx_22040237_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          INST_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              req_valid,
   output logic [31:0]       req_addr,
   input  logic              req_ready,
   input  logic              rsp_valid,
   input  logic [INST_W-1:0] rsp_data,
   input  logic              rsp_err,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [31:0]       inst_pc,
   input  logic              inst_ready,
   input  logic              jump_valid,
   input  logic [31:0]       pc_jump_addr,
   input  logic              flush_valid,
   input  logic [31:0]       flush_pc,
   output logic              fault,
   output logic [31:0]       fault_pc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_OUT,
      S_HALT
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        drop;
   logic        drop_next;
   logic        load_inst;
   logic        set_fault;
   logic [31:0] fault_addr;

   assign req_valid  = (state == S_REQ);
   assign inst_valid = (state == S_OUT);
   assign req_addr   = pc;

   // Flush wins over everything but the halted state; drop marks a response
   // that is still owed by memory for a request we no longer care about.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      drop_next  = drop;
      load_inst  = 1'b0;
      set_fault  = 1'b0;
      fault_addr = pc;
      case (state)
         S_IDLE: begin
            if (flush_valid) pc_next = flush_pc;
            state_next = S_REQ;
         end
         S_REQ: begin
            if (req_ready) state_next = S_WAIT;
            if (flush_valid) begin
               pc_next = flush_pc;
               if (req_ready) drop_next = 1'b1;
            end
         end
         S_WAIT: begin
            if (flush_valid) begin
               pc_next   = flush_pc;
               drop_next = !rsp_valid;
               if (rsp_valid) state_next = S_REQ;
            end else if (rsp_valid) begin
               if (drop) begin
                  drop_next  = 1'b0;
                  state_next = S_REQ;
               end else if (rsp_err) begin
                  set_fault  = 1'b1;
                  fault_addr = pc;
                  state_next = S_HALT;
               end else begin
                  load_inst  = 1'b1;
                  state_next = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (flush_valid) begin
               pc_next    = flush_pc;
               state_next = S_REQ;
            end else if (inst_ready) begin
               pc_next    = jump_valid ? pc_jump_addr : pc + 32'd4;
               state_next = S_REQ;
            end
         end
         S_HALT: begin
            state_next = S_HALT;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Any redirect to a non-word-aligned target stops fetch before a request goes out.
      if (state != S_HALT && pc_next[1:0] != 2'b00) begin
         set_fault  = 1'b1;
         fault_addr = pc_next;
         drop_next  = 1'b0;
         state_next = S_HALT;
      end
   end

   // State, PC and the decode-facing instruction registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         drop     <= 1'b0;
         inst     <= '0;
         inst_pc  <= 32'd0;
         fault    <= 1'b0;
         fault_pc <= 32'd0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         drop  <= drop_next;
         if (load_inst) begin
            inst    <= rsp_data;
            inst_pc <= pc;
         end
         if (set_fault) begin
            fault    <= 1'b1;
            fault_pc <= fault_addr;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Self-checking bench for ysyx_22040237_ifu: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetch stream and a toy memory.
module tb_ysyx_22040237_ifu;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready = 1'b0;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data = 32'd0;
   logic        rsp_err = 1'b0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
   logic        jump_valid = 1'b0;
   logic [31:0] pc_jump_addr = 32'd0;
   logic        flush_valid = 1'b0;
   logic [31:0] flush_pc = 32'd0;
   logic        fault;
   logic [31:0] fault_pc;

   ysyx_22040237_ifu #(.RESET_PC(RESET_PC), .INST_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_addr(req_addr),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_data(rsp_data),
      .rsp_err(rsp_err),
      .inst_valid(inst_valid),
      .inst(inst),
      .inst_pc(inst_pc),
      .inst_ready(inst_ready),
      .jump_valid(jump_valid),
      .pc_jump_addr(pc_jump_addr),
      .flush_valid(flush_valid),
      .flush_pc(flush_pc),
      .fault(fault),
      .fault_pc(fault_pc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Stimulus knobs for the next cycle.
   logic        rand_mode = 1'b0;
   logic        drv_req_ready = 1'b1;
   logic        drv_inst_ready = 1'b1;
   logic        drv_jump = 1'b0;
   logic [31:0] drv_jaddr = 32'd0;
   logic        drv_flush = 1'b0;
   logic [31:0] drv_faddr = 32'd0;
   logic        force_err = 1'b0;
   int          fixed_delay = 0;

   // Reference model: expected fetch PC, what is in flight, and fault status.
   logic [31:0] m_pc;
   logic        m_idle;
   logic        m_pending;
   logic        m_stale;
   int          m_delay;
   logic [31:0] m_paddr;
   logic        m_out;
   logic        m_halt;
   logic [31:0] m_fpc;
   logic        exp_req;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a == RESET_PC) ? 32'h0000_0413 : (a ^ 32'hA5A5_0013);
   endfunction

   function automatic logic [31:0] pickTarget();
      int r;
      r = $urandom_range(0, 59);
      if (r == 0) return RESET_PC | ($urandom & 32'h0000_0FFC) | 32'd2;
      if (r == 1) return 32'hFFFF_FFFC;
      return RESET_PC | ($urandom & 32'h0000_FFFC);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic modelHalt(input logic [31:0] addr);
      m_halt = 1'b1;
      m_fpc  = addr;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic stepCycle();
      logic        rsp_now;
      logic        hs;
      logic [31:0] target;
      exp_req = !(m_halt || m_pending || m_out || m_idle);
      checkOutput("fault", 32'(fault), 32'(m_halt));
      if (m_halt) checkOutput("fault_pc", fault_pc, m_fpc);
      checkOutput("req_valid", 32'(req_valid), 32'(exp_req));
      if (exp_req) checkOutput("req_addr", req_addr, m_pc);
      checkOutput("inst_valid", 32'(inst_valid), 32'(m_out && !m_halt));
      if (m_out && !m_halt) begin
         checkOutput("inst_pc", inst_pc, m_pc);
         checkOutput("inst", inst, memWord(m_pc));
      end

      rsp_now = m_pending && (m_delay == 0);
      if (m_pending && m_delay != 0) m_delay--;
      rsp_valid = rsp_now;
      rsp_data  = rand_mode ? $urandom : 32'd0;
      rsp_err   = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rsp_now) begin
         rsp_data = memWord(m_paddr);
         rsp_err  = rand_mode ? ($urandom_range(0, 149) == 0) : force_err;
      end else if (rand_mode && !m_pending && (m_idle || exp_req) && $urandom_range(0, 7) == 0) begin
         rsp_valid = 1'b1;
      end
      req_ready    = drv_req_ready;
      inst_ready   = drv_inst_ready;
      jump_valid   = drv_jump;
      pc_jump_addr = drv_jaddr;
      flush_valid  = drv_flush;
      flush_pc     = drv_faddr;

      if (rsp_now) m_pending = 1'b0;
      if (!m_halt) begin
         hs     = exp_req && drv_req_ready;
         m_idle = 1'b0;
         if (rsp_now) begin
            if (drv_flush || m_stale) m_stale = 1'b0;
            else if (rsp_err) modelHalt(m_pc);
            else m_out = 1'b1;
         end else if (m_out && drv_inst_ready && !drv_flush) begin
            m_out  = 1'b0;
            target = drv_jump ? drv_jaddr : m_pc + 32'd4;
            m_pc   = target;
            if (target[1:0] != 2'b00) modelHalt(target);
         end
         if (hs) begin
            m_pending = 1'b1;
            m_paddr   = m_pc;
            m_delay   = rand_mode ? $urandom_range(0, 2) : fixed_delay;
            m_stale   = 1'b0;
         end
         if (drv_flush && !m_halt) begin
            m_pc  = drv_faddr;
            m_out = 1'b0;
            if (m_pending) m_stale = 1'b1;
            if (drv_faddr[1:0] != 2'b00) modelHalt(drv_faddr);
         end
      end
      @(negedge clk);
   endtask

   task automatic applyStimulus();
      drv_req_ready  = $urandom_range(0, 3) != 0;
      drv_inst_ready = $urandom_range(0, 2) != 0;
      drv_jump       = $urandom_range(0, 2) == 0;
      drv_jaddr      = pickTarget();
      drv_flush      = $urandom_range(0, 14) == 0;
      drv_faddr      = pickTarget();
      stepCycle();
   endtask

   task automatic applyReset();
      rst         = 1'b1;
      rsp_valid   = 1'b0;
      flush_valid = 1'b0;
      jump_valid  = 1'b0;
      #1;
      checkOutput("rst_req_valid", 32'(req_valid), 32'd0);
      checkOutput("rst_req_addr", req_addr, RESET_PC);
      checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
      checkOutput("rst_inst", inst, 32'd0);
      checkOutput("rst_inst_pc", inst_pc, 32'd0);
      checkOutput("rst_fault", 32'(fault), 32'd0);
      checkOutput("rst_fault_pc", fault_pc, 32'd0);
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      m_pc      = RESET_PC;
      m_idle    = 1'b1;
      m_pending = 1'b0;
      m_stale   = 1'b0;
      m_delay   = 0;
      m_paddr   = 32'd0;
      m_out     = 1'b0;
      m_halt    = 1'b0;
      m_fpc     = 32'd0;
   endtask

   task automatic waitReq(input string tag, input logic [31:0] addr);
      int n = 0;
      while (!req_valid && n < 20) begin
         stepCycle();
         n++;
      end
      checkOutput({tag, "_seen"}, 32'(req_valid), 32'd1);
      checkOutput(tag, req_addr, addr);
   endtask

   task automatic waitInst(input string tag, input logic [31:0] pc);
      int n = 0;
      while (!inst_valid && n < 20) begin
         stepCycle();
         n++;
      end
      checkOutput({tag, "_seen"}, 32'(inst_valid), 32'd1);
      checkOutput(tag, inst_pc, pc);
   endtask

   initial begin
      @(negedge clk);
      applyReset();

      // First fetch, then a held instruction, then a plain pc+4 step.
      drv_inst_ready = 1'b0;
      waitReq("first_req", 32'h8000_0000);
      waitInst("first_inst_pc", 32'h8000_0000);
      checkOutput("first_inst", inst, 32'h0000_0413);
      repeat (5) stepCycle();
      drv_inst_ready = 1'b1;
      stepCycle();
      waitReq("seq_req", 32'h8000_0004);

      // A jump outside a handshake is ignored; a jump on consume redirects.
      drv_inst_ready = 1'b0;
      drv_jump = 1'b1;
      drv_jaddr = 32'h8000_0300;
      waitInst("idle_jump_inst_pc", 32'h8000_0004);
      drv_inst_ready = 1'b1;
      drv_jaddr = 32'h8000_0100;
      stepCycle();
      drv_jump = 1'b0;
      waitReq("jump_req", 32'h8000_0100);

      // Flush during a wait with a same-cycle response, then flush on the accept cycle.
      stepCycle();
      drv_flush = 1'b1;
      drv_faddr = 32'h8000_0200;
      stepCycle();
      drv_flush = 1'b0;
      waitReq("flush_wait_req", 32'h8000_0200);
      drv_flush = 1'b1;
      drv_faddr = 32'h8000_0400;
      stepCycle();
      drv_flush = 1'b0;
      waitReq("flush_accept_req", 32'h8000_0400);
      drv_inst_ready = 1'b0;
      waitInst("flush_inst_pc", 32'h8000_0400);

      // PC wraps past the top of the address space.
      drv_inst_ready = 1'b1;
      drv_jump = 1'b1;
      drv_jaddr = 32'hFFFF_FFFC;
      stepCycle();
      drv_jump = 1'b0;
      drv_inst_ready = 1'b0;
      waitInst("top_inst_pc", 32'hFFFF_FFFC);
      drv_inst_ready = 1'b1;
      stepCycle();
      waitReq("wrap_req", 32'h0000_0000);

      // Misaligned jump target halts fetch.
      drv_inst_ready = 1'b0;
      waitInst("pre_mis_inst_pc", 32'h0000_0000);
      drv_inst_ready = 1'b1;
      drv_jump = 1'b1;
      drv_jaddr = 32'h8000_0102;
      stepCycle();
      drv_jump = 1'b0;
      checkOutput("mis_fault", 32'(fault), 32'd1);
      checkOutput("mis_fault_pc", fault_pc, 32'h8000_0102);
      repeat (5) stepCycle();

      // Memory error on the third fetch.
      applyReset();
      for (int n = 0; n < 40 && !(req_valid && req_addr == 32'h8000_0008); n++) stepCycle();
      checkOutput("err_req", req_addr, 32'h8000_0008);
      force_err = 1'b1;
      stepCycle();
      stepCycle();
      force_err = 1'b0;
      checkOutput("err_fault", 32'(fault), 32'd1);
      checkOutput("err_fault_pc", fault_pc, 32'h8000_0008);
      stepCycle();

      // Reset while a response is still outstanding.
      applyReset();
      fixed_delay = 3;
      waitReq("pre_rst_req", 32'h8000_0000);
      stepCycle();
      stepCycle();
      applyReset();
      fixed_delay = 0;
      repeat (4) stepCycle();

      // Randomized episodes, each ending in a reset from whatever state it reached.
      rand_mode = 1'b1;
      for (int e = 0; e < 25; e++) begin
         applyReset();
         for (int c = 0; c < 200; c++) applyStimulus();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
